// File: rtl/sb_param_corner.sv
// sb_param_corner: parameterised switch-box corner joining a bottom (chany)
// and a left (chanx) channel. A serial configuration chain holds one field
// per outgoing track, {en, sel}, choosing which incoming track of the other
// side drives it. A small FSM counts shifted bits and only enables routing
// after a load with exactly CFG_BITS bits.
// Optional feature: define SB_OUT_REG_EN to register all track outputs.
module sb_param_corner #(
  parameter int CHAN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_en,
  input  logic              cfg_head,
  output logic              cfg_tail,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [0:CHAN_W-1] chany_bottom_in,
  input  logic [0:CHAN_W-1] chanx_left_in,
  output logic [0:CHAN_W-1] chany_bottom_out,
  output logic [0:CHAN_W-1] chanx_left_out
);

  localparam int SEL_W    = $clog2(CHAN_W);
  localparam int FLD_W    = SEL_W + 1;
  localparam int CFG_BITS = 2 * CHAN_W * FLD_W;
  // Counter must reach CFG_BITS+1 so an over-long load is distinguishable.
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  // Power-up routing: left outputs take bottom track j-1, bottom outputs
  // take left track j+1, all enabled.
  function automatic logic [CFG_BITS-1:0] default_cfg();
    logic [CFG_BITS-1:0] v;
    v = '0;
    for (int j = 0; j < CHAN_W; j++) begin
      v[j*FLD_W +: FLD_W]          = {1'b1, SEL_W'((j + CHAN_W - 1) % CHAN_W)};
      v[(CHAN_W+j)*FLD_W +: FLD_W] = {1'b1, SEL_W'((j + 1) % CHAN_W)};
    end
    return v;
  endfunction

  localparam logic [CFG_BITS-1:0] CFG_DEFAULT = default_cfg();

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_LOAD,
    ST_ERROR
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CFG_BITS-1:0] cfg_reg;
  logic                done_reg;
  logic                err_reg;

  logic [0:CHAN_W-1]   route_x;
  logic [0:CHAN_W-1]   route_y;

  // Chain shift, bit counter and load-validation FSM with registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_ACTIVE;
      cnt_reg   <= '0;
      cfg_reg   <= CFG_DEFAULT;
      done_reg  <= 1'b1;
      err_reg   <= 1'b0;
    end else if (cfg_en) begin
      // The chain never stops at CFG_BITS: surplus bits fall out of cfg_tail.
      cfg_reg   <= {cfg_head, cfg_reg[CFG_BITS-1:1]};
      state_reg <= ST_LOAD;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      if (state_reg != ST_LOAD) begin
        cnt_reg <= CNT_W'(1);
      end else if (cnt_reg != CNT_SAT) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end else if (state_reg == ST_LOAD) begin
      if (cnt_reg == CNT_FULL) begin
        state_reg <= ST_ACTIVE;
        done_reg  <= 1'b1;
        err_reg   <= 1'b0;
      end else begin
        state_reg <= ST_ERROR;
        done_reg  <= 1'b0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign cfg_tail = cfg_reg[0];
  assign cfg_done = done_reg;
  assign cfg_err  = err_reg;

  // One multiplexer per outgoing track; routing is forced low outside ACTIVE.
  generate
    for (genvar gi = 0; gi < CHAN_W; gi++) begin : g_track
      logic [FLD_W-1:0] fld_x;
      logic [FLD_W-1:0] fld_y;
      assign fld_x = cfg_reg[gi*FLD_W +: FLD_W];
      assign fld_y = cfg_reg[(CHAN_W+gi)*FLD_W +: FLD_W];
      assign route_x[gi] = (state_reg == ST_ACTIVE) && fld_x[FLD_W-1]
                           && chany_bottom_in[fld_x[SEL_W-1:0]];
      assign route_y[gi] = (state_reg == ST_ACTIVE) && fld_y[FLD_W-1]
                           && chanx_left_in[fld_y[SEL_W-1:0]];
    end
  endgenerate

`ifdef SB_OUT_REG_EN
  logic [0:CHAN_W-1] x_out_reg;
  logic [0:CHAN_W-1] y_out_reg;

  // Registered track outputs: gating is already folded into route_x/route_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out_reg <= '0;
      y_out_reg <= '0;
    end else begin
      x_out_reg <= route_x;
      y_out_reg <= route_y;
    end
  end

  assign chanx_left_out   = x_out_reg;
  assign chany_bottom_out = y_out_reg;
`else
  assign chanx_left_out   = route_x;
  assign chany_bottom_out = route_y;
`endif

endmodule

// File: tb/tb_sb_param_corner.sv
// tb_sb_param_corner: table-driven routing checks through a scoreboard queue,
// plus hand-written load sequences (exact, short, long, disabled, aborted).
// Works with or without SB_OUT_REG_EN (adds one cycle before sampling).
module tb_sb_param_corner;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_en;
  logic          cfg_head;
  logic          cfg_tail;
  logic          cfg_done;
  logic          cfg_err;
  logic [0:CW-1] chany_bottom_in;
  logic [0:CW-1] chanx_left_in;
  logic [0:CW-1] chany_bottom_out;
  logic [0:CW-1] chanx_left_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic [0:CW-1] b_in;
    logic [0:CW-1] l_in;
    logic [0:CW-1] x_exp;
    logic [0:CW-1] y_exp;
    logic          done_exp;
    logic          err_exp;
  } vec_t;

  vec_t sb_q[$];

  sb_param_corner #(.CHAN_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_en           (cfg_en),
    .cfg_head         (cfg_head),
    .cfg_tail         (cfg_tail),
    .cfg_done         (cfg_done),
    .cfg_err          (cfg_err),
    .chany_bottom_in  (chany_bottom_in),
    .chanx_left_in    (chanx_left_in),
    .chany_bottom_out (chany_bottom_out),
    .chanx_left_out   (chanx_left_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end else begin
      $display("ok   %s: %b", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push expectation, drive inputs, wait for the DUT result, pop and compare.
  task automatic drive_check(input vec_t v);
    vec_t e;
    sb_q.push_back(v);
    chany_bottom_in = v.b_in;
    chanx_left_in   = v.l_in;
`ifdef SB_OUT_REG_EN
    tick();
`else
    #1;
`endif
    e = sb_q.pop_front();
    chk({e.name, ".x"}, chanx_left_out, e.x_exp);
    chk({e.name, ".y"}, chany_bottom_out, e.y_exp);
    chk({e.name, ".done"}, {3'b0, cfg_done}, {3'b0, e.done_exp});
    chk({e.name, ".err"}, {3'b0, cfg_err}, {3'b0, e.err_exp});
  endtask

  // Shift n bits, bits[0] first; bits[0] ends up at chain bit 0 after 24.
  task automatic shift_in(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en   = 1'b1;
      cfg_head = bits[i];
      tick();
    end
    cfg_en = 1'b0;
  endtask

  vec_t dflt_tab[5];
  vec_t id_tab[4];
  logic [23:0] ident;
  logic [63:0] rnd;
  logic [3:0]  sel4;

  initial begin
    // Default routing: x[j] <- b[(j-1)%4], y[j] <- l[(j+1)%4]; literals are index 0 first.
    dflt_tab[0] = '{"dflt0", 4'b1000, 4'b1000, 4'b0100, 4'b0001, 1'b1, 1'b0};
    dflt_tab[1] = '{"dflt1", 4'b0001, 4'b0100, 4'b1000, 4'b1000, 1'b1, 1'b0};
    dflt_tab[2] = '{"dflt2", 4'b0110, 4'b0011, 4'b0011, 4'b0110, 1'b1, 1'b0};
    dflt_tab[3] = '{"dflt3", 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0};
    dflt_tab[4] = '{"dflt4", 4'b0000, 4'b1010, 4'b0000, 4'b0101, 1'b1, 1'b0};
    // Identity routing: outputs mirror the opposite side bit-for-bit.
    id_tab[0] = '{"id0", 4'b1000, 4'b0001, 4'b1000, 4'b0001, 1'b1, 1'b0};
    id_tab[1] = '{"id1", 4'b0110, 4'b1001, 4'b0110, 4'b1001, 1'b1, 1'b0};
    id_tab[2] = '{"id2", 4'b1011, 4'b0100, 4'b1011, 4'b0100, 1'b1, 1'b0};
    id_tab[3] = '{"id3", 4'b0001, 4'b1110, 4'b0001, 4'b1110, 1'b1, 1'b0};

    ident = '0;
    for (int j = 0; j < CW; j++) begin
      sel4 = 4'(j);
      ident[j*3 +: 3]      = {1'b1, sel4[1:0]};
      ident[(CW+j)*3 +: 3] = {1'b1, sel4[1:0]};
    end

    reset = 1'b1; cfg_en = 1'b0; cfg_head = 1'b0;
    chany_bottom_in = 4'b1000; chanx_left_in = 4'b1000;
    tick();
    tick();
    chk("rst.done", {3'b0, cfg_done}, 4'b0001);
    chk("rst.err",  {3'b0, cfg_err},  4'b0000);
    chk("rst.tail", {3'b0, cfg_tail}, 4'b0001);
`ifdef SB_OUT_REG_EN
    chk("rst.x_zero", chanx_left_out, 4'b0000);
    chk("rst.y_zero", chany_bottom_out, 4'b0000);
`endif
    reset = 1'b0;

    for (int i = 0; i < 5; i++) drive_check(dflt_tab[i]);

    // Exact 24-bit identity load.
    shift_in({40'b0, ident}, 24);
    chk("load.done_low", {3'b0, cfg_done}, 4'b0000);
    tick();
    chk("id.done", {3'b0, cfg_done}, 4'b0001);
    chk("id.err",  {3'b0, cfg_err},  4'b0000);
    for (int i = 0; i < 4; i++) drive_check(id_tab[i]);

    // Short load (23 bits) must land in ERROR with tracks blanked.
    shift_in({40'b0, ident}, 23);
    tick();
    drive_check('{"short", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1});
    shift_in({40'b0, ident}, 24);
    tick();
    drive_check('{"recover", 4'b0101, 4'b1100, 4'b0101, 4'b1100, 1'b1, 1'b0});

    // Long load (30 bits): tail shows the bit shifted 24 shifts earlier.
    rnd = {$urandom, $urandom};
    for (int n = 1; n <= 30; n++) begin
      cfg_en = 1'b1;
      cfg_head = rnd[n-1];
      tick();
      if (n >= 24) chk($sformatf("long.tail%0d", n), {3'b0, cfg_tail}, {3'b0, rnd[n-24]});
    end
    cfg_en = 1'b0;
    tick();
    drive_check('{"long", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1});

    // All fields disabled: ACTIVE but silent.
    shift_in(64'b0, 24);
    tick();
    drive_check('{"off0", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0});
    drive_check('{"off1", 4'b1010, 4'b0110, 4'b0000, 4'b0000, 1'b1, 1'b0});

    // Reset mid-load (after 10 bits, with cfg_en still high) restores defaults.
    shift_in(64'h0, 10);
    reset = 1'b1; cfg_en = 1'b1; cfg_head = 1'b0;
    tick();
    reset = 1'b0; cfg_en = 1'b0;
    chk("abort.done", {3'b0, cfg_done}, 4'b0001);
    chk("abort.err",  {3'b0, cfg_err},  4'b0000);
    chk("abort.tail", {3'b0, cfg_tail}, 4'b0001);
    drive_check(dflt_tab[0]);
    drive_check(dflt_tab[2]);

`ifdef SB_OUT_REG_EN
    // Registered outputs hold the old value until the next edge.
    chany_bottom_in = 4'b0001;
    #1;
    chk("lag.before", chanx_left_out, 4'b0011);
    tick();
    chk("lag.after", chanx_left_out, 4'b1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_param_corner.md
SB_PARAM_CORNER -- requirements
Module: sb_param_corner

Interface
REQ-001 SHALL have parameter CHAN_W, default 4: tracks per side; power of two, minimum 2.
REQ-002 SHALL have derived localparams SEL_W = clog2(CHAN_W), FLD_W = SEL_W+1, CFG_BITS = 2*CHAN_W*FLD_W (24 at default).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_en, input, 1: configuration shift enable.
REQ-006 SHALL have port cfg_head, input, 1: configuration chain serial input.
REQ-007 SHALL have port cfg_tail, output, 1: configuration chain serial output, equal to chain bit 0.
REQ-008 SHALL have port cfg_done, output, 1: configuration valid, routing active.
REQ-009 SHALL have port cfg_err, output, 1: last load had a wrong bit count.
REQ-010 SHALL have port chany_bottom_in, input, [0:CHAN_W-1]: bottom-side incoming tracks.
REQ-011 SHALL have port chanx_left_in, input, [0:CHAN_W-1]: left-side incoming tracks.
REQ-012 SHALL have port chany_bottom_out, output, [0:CHAN_W-1]: bottom-side outgoing tracks.
REQ-013 SHALL have port chanx_left_out, output, [0:CHAN_W-1]: left-side outgoing tracks.

Function
REQ-014 SHALL hold a CFG_BITS-bit chain cfg[CFG_BITS-1:0]; on each clk with cfg_en=1: cfg <= {cfg_head, cfg[CFG_BITS-1:1]}.
REQ-015 SHALL map the field for chanx_left_out[j] to cfg[j*FLD_W +: FLD_W] and the field for chany_bottom_out[j] to cfg[(CHAN_W+j)*FLD_W +: FLD_W]; each field is {en (MSB), sel[SEL_W-1:0]}.
REQ-016 In ACTIVE, SHALL drive chanx_left_out[j] = en ? chany_bottom_in[sel] : 0, and chany_bottom_out[j] = en ? chanx_left_in[sel] : 0.
REQ-017 SHALL implement FSM states ACTIVE, LOAD and ERROR; reset enters ACTIVE.
REQ-018 In any state, cfg_en=1 SHALL move the FSM to LOAD and restart the shift counter at 1 for that shift.
REQ-019 In LOAD with cfg_en=1, the shift counter SHALL increment and saturate at CFG_BITS+1.
REQ-020 In LOAD with cfg_en=0: counter==CFG_BITS SHALL go to ACTIVE; any other counter value SHALL go to ERROR.
REQ-021 In LOAD and ERROR, all track outputs SHALL be 0, cfg_done=0; cfg_err=1 only in ERROR.
REQ-022 The chain SHALL keep shifting past CFG_BITS, so excess bits pass to cfg_tail; cfg_tail SHALL not be gated in any state.
REQ-023 cfg_done SHALL be 1 exactly in ACTIVE.
REQ-024 Track in-to-out latency SHALL be 0 cycles without SB_OUT_REG_EN.

Reset
REQ-025 reset SHALL have priority over cfg_en.
REQ-026 Reset SHALL load the default pattern: chanx_left_out[j] field = {1, (j-1) mod CHAN_W}, chany_bottom_out[j] field = {1, (j+1) mod CHAN_W}.
REQ-027 After reset: state ACTIVE, counter 0, cfg_done=1, cfg_err=0, cfg_tail=1 at CHAN_W=4.
REQ-028 Reset during LOAD SHALL abort the load and restore the default pattern on the next edge.

Configuration
REQ-029 With macro SB_OUT_REG_EN defined, all track outputs SHALL be registered: reset to 0, 1-cycle latency, with LOAD/ERROR gating applied before the register.
REQ-030 Without SB_OUT_REG_EN, track outputs SHALL be purely combinational per REQ-016 and REQ-021.

Verification
REQ-031 Reset, CHAN_W=4, chany_bottom_in=4'b1000 (bit0=1) -> chanx_left_out[1]=1, other outputs 0; chanx_left_in[0]=1 -> chany_bottom_out[3]=1; cfg_done=1, cfg_tail=1.
REQ-032 Shift 24 bits so every field = {1, j} (identity), then drop cfg_en -> cfg_done=1 next cycle, chanx_left_out equals chany_bottom_in bit-for-bit.
REQ-033 Shift 23 bits then drop cfg_en -> cfg_err=1, cfg_done=0, all outputs 0; a following correct 24-bit load -> cfg_err=0, cfg_done=1.
REQ-034 Shift 30 bits -> counter saturates at 25, ERROR entered; cfg_tail reproduces cfg_head delayed 24 cycles.
REQ-035 Load all fields with en=0 -> all outputs 0 for any input; assert reset mid-load (after bit 10) -> default pattern restored, cfg_done=1.
REQ-036 With SB_OUT_REG_EN defined, repeat REQ-031 -> outputs lag inputs by exactly 1 cycle and are 0 in the reset cycle.
